vm2002_change_dispenser: RTL and testbench

//  Return-side partner of the vm2002 vending FSM. Takes the balance the FSM computes after a sale.

---
 rtl/vm2002_pkg.sv | 39 +++
 rtl/vm2002_coin_sel.sv | 29 ++
 rtl/vm2002_change_dispenser.sv | 181 ++++++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vm2002_pkg.sv
// rtl/vm2002_pkg.sv - shared coin/state types and coin values for the vm2002 change path
//
// Contents:
//   coin_t       2-bit coin code, same encoding the vending FSM uses on its user side
//   *_VAL        coin values in cents
//   chg_state_t  change dispenser FSM states
//   coin_value   coin code -> value in cents
package vm2002_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    QUARTER = 2'b11
  } coin_t;

  localparam int unsigned NICKEL_VAL  = 5;
  localparam int unsigned DIME_VAL    = 10;
  localparam int unsigned QUARTER_VAL = 25;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    GAP,
    DONE,
    FAULT
  } chg_state_t;

  function automatic logic [4:0] coin_value(input coin_t c);
    case (c)
      NICKEL:  return 5'(NICKEL_VAL);
      DIME:    return 5'(DIME_VAL);
      QUARTER: return 5'(QUARTER_VAL);
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm2002_coin_sel.sv
// rtl/vm2002_coin_sel.sv - greedy largest-coin selector for the amount still owed
//
// Ports:
//   remaining  in   BAL_W  cents still owed
//   coin       out  coin_t largest coin not exceeding remaining (NONE below 5 cents)
//   value      out  BAL_W  value of coin in cents, zero-extended
module vm2002_coin_sel
  import vm2002_pkg::*;
#(
  parameter int unsigned BAL_W = 16
) (
  input  logic [BAL_W-1:0] remaining,
  output coin_t            coin,
  output logic [BAL_W-1:0] value
);

  always_comb begin
    coin = NONE;
    if (remaining >= BAL_W'(QUARTER_VAL)) begin
      coin = QUARTER;
    end else if (remaining >= BAL_W'(DIME_VAL)) begin
      coin = DIME;
    end else if (remaining >= BAL_W'(NICKEL_VAL)) begin
      coin = NICKEL;
    end
    value = BAL_W'(coin_value(coin));
  end

endmodule

// File: rtl/vm2002_change_dispenser.sv
// rtl/vm2002_change_dispenser.sv - pays a change balance out as a stream of coin handshakes
//
// Ports:
//   clk           in   1      clock, posedge
//   hrst          in   1      synchronous active-high hard reset
//   req_valid     in   1      change request, taken only while req_ready
//   req_balance   in   BAL_W  cents owed, sampled on accept
//   req_ready     out  1      high only in IDLE
//   coin_valid    out  1      coin_out valid, held until coin_ack
//   coin_out      out  2      00 none, 01 nickel, 10 dime, 11 quarter
//   coin_ack      in   1      ejector took the coin this cycle
//   remaining     out  BAL_W  cents still owed
//   coins_issued  out  8      acknowledged coins for this request, saturating
//   done          out  1      one-cycle pulse at end of request
//   short_change  out  1      with done: 1..4 cents could not be paid
//   fault         out  1      sticky ack-timeout flag, cleared only by hrst
module vm2002_change_dispenser
  import vm2002_pkg::*;
#(
  parameter int unsigned BAL_W     = 16,
  parameter int unsigned EJECT_GAP = 2,
  parameter int unsigned ACK_TMO   = 255
) (
  input  logic             clk,
  input  logic             hrst,
  input  logic             req_valid,
  input  logic [BAL_W-1:0] req_balance,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_out,
  input  logic             coin_ack,
  output logic [BAL_W-1:0] remaining,
  output logic [7:0]       coins_issued,
  output logic             done,
  output logic             short_change,
  output logic             fault
);

  localparam int unsigned GAP_W = $clog2(EJECT_GAP + 2);
  localparam int unsigned TMO_W = $clog2(ACK_TMO + 2);

  chg_state_t       state, state_d;
  coin_t            coin_q, coin_d;
  logic             coin_valid_q, coin_valid_d;
  logic [BAL_W-1:0] remaining_q, remaining_d;
  logic [7:0]       coins_q, coins_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic             fault_q, fault_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;

  coin_t            sel_coin;
  logic [BAL_W-1:0] sel_value;
  logic             gap_last;
  logic             tmo_last;

  // remaining is frozen while a coin is offered, so the selector output in
  // ISSUE is still the value of the coin being offered.
  vm2002_coin_sel #(
    .BAL_W(BAL_W)
  ) u_coin_sel (
    .remaining(remaining_q),
    .coin     (sel_coin),
    .value    (sel_value)
  );

  // The SELECT cycle is itself a cycle with coin_valid low, so GAP lasts one
  // cycle less than EJECT_GAP to make the low time between coins EJECT_GAP.
  assign gap_last = (32'(gap_cnt) + 32'd2 >= EJECT_GAP);
  // Last waiting cycle: coin_valid has then been high for ACK_TMO cycles.
  assign tmo_last = (32'(tmo_cnt) + 32'd1 >= ACK_TMO);

  always_ff @(posedge clk) begin
    if (hrst) begin
      state        <= IDLE;
      coin_q       <= NONE;
      coin_valid_q <= 1'b0;
      remaining_q  <= '0;
      coins_q      <= '0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      fault_q      <= 1'b0;
      gap_cnt      <= '0;
      tmo_cnt      <= '0;
    end else begin
      state        <= state_d;
      coin_q       <= coin_d;
      coin_valid_q <= coin_valid_d;
      remaining_q  <= remaining_d;
      coins_q      <= coins_d;
      done_q       <= done_d;
      short_q      <= short_d;
      fault_q      <= fault_d;
      gap_cnt      <= gap_cnt_d;
      tmo_cnt      <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    coin_d       = coin_q;
    coin_valid_d = coin_valid_q;
    remaining_d  = remaining_q;
    coins_d      = coins_q;
    done_d       = 1'b0;
    short_d      = 1'b0;
    fault_d      = fault_q;
    gap_cnt_d    = gap_cnt;
    tmo_cnt_d    = tmo_cnt;

    case (state)
      IDLE: begin
        if (req_valid) begin
          remaining_d = req_balance;
          coins_d     = '0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (sel_coin != NONE) begin
          coin_d       = sel_coin;
          coin_valid_d = 1'b1;
          tmo_cnt_d    = '0;
          state_d      = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      ISSUE: begin
        // ack takes priority over a timeout expiring in the same cycle
        if (coin_ack) begin
          remaining_d  = remaining_q - sel_value;
          if (coins_q != 8'hFF) begin
            coins_d = coins_q + 8'd1;
          end
          coin_valid_d = 1'b0;
          coin_d       = NONE;
          gap_cnt_d    = '0;
          state_d      = (EJECT_GAP > 1) ? GAP : SELECT;
        end else if (tmo_last) begin
          coin_valid_d = 1'b0;
          coin_d       = NONE;
          fault_d      = 1'b1;
          state_d      = FAULT;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = SELECT;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        short_d = (remaining_q != '0);
        state_d = IDLE;
      end
      FAULT: begin
        coin_valid_d = 1'b0;
        coin_d       = NONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready    = (state == IDLE);
  assign coin_valid   = coin_valid_q;
  assign coin_out     = coin_q;
  assign remaining    = remaining_q;
  assign coins_issued = coins_q;
  assign done         = done_q;
  assign short_change = short_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// tb/tb_vm2002_change_dispenser.sv - directed scoreboard bench for vm2002_change_dispenser
module tb_vm2002_change_dispenser;
  import vm2002_pkg::*;

  localparam int BAL_W     = 16;
  localparam int EJECT_GAP = 2;
  localparam int ACK_TMO   = 255;

  logic             clk = 1'b0;
  logic             hrst;
  logic             req_valid;
  logic [BAL_W-1:0] req_balance;
  logic             req_ready;
  logic             coin_valid;
  logic [1:0]       coin_out;
  logic             coin_ack;
  logic [BAL_W-1:0] remaining;
  logic [7:0]       coins_issued;
  logic             done;
  logic             short_change;
  logic             fault;

  int    vectors     = 0;
  int    miscompares = 0;
  coin_t exp_q[$];

  vm2002_change_dispenser #(
    .BAL_W    (BAL_W),
    .EJECT_GAP(EJECT_GAP),
    .ACK_TMO  (ACK_TMO)
  ) dut (
    .clk         (clk),
    .hrst        (hrst),
    .req_valid   (req_valid),
    .req_balance (req_balance),
    .req_ready   (req_ready),
    .coin_valid  (coin_valid),
    .coin_out    (coin_out),
    .coin_ack    (coin_ack),
    .remaining   (remaining),
    .coins_issued(coins_issued),
    .done        (done),
    .short_change(short_change),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Greedy reference: queue the expected coins, return the unpayable residue.
  function automatic int push_greedy(input int bal);
    int b;
    b = bal;
    while (b >= 25) begin exp_q.push_back(QUARTER); b -= 25; end
    while (b >= 10) begin exp_q.push_back(DIME);    b -= 10; end
    while (b >= 5)  begin exp_q.push_back(NICKEL);  b -= 5;  end
    return b;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"},    32'(req_ready),    1);
    chk({tag, "_coin_valid"},   32'(coin_valid),   0);
    chk({tag, "_coin_out"},     32'(coin_out),     0);
    chk({tag, "_remaining"},    32'(remaining),    0);
    chk({tag, "_coins_issued"}, 32'(coins_issued), 0);
    chk({tag, "_done"},         32'(done),         0);
    chk({tag, "_short_change"}, 32'(short_change), 0);
    chk({tag, "_fault"},        32'(fault),        0);
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send_req(input int bal);
    req_valid   = 1'b1;
    req_balance = bal[BAL_W-1:0];
    @(negedge clk);
    req_valid   = 1'b0;
  endtask

  // Acks each offered coin ack_delay cycles after it appears, checks it against
  // the scoreboard, and returns on the negedge where done is seen.
  task automatic serve(input string tag, input int ack_delay, output int last_gap);
    int    waitc, low, ncoins, nexp;
    bit    seen, fin;
    coin_t e;
    waitc = 0; low = 0; ncoins = 0; seen = 0; fin = 0;
    nexp = exp_q.size();
    last_gap = -1;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        fin = 1;
        break;
      end
      if (coin_valid) begin
        if (seen && low > 0) last_gap = low;
        low = 0;
        if (waitc == ack_delay) begin
          coin_ack = 1'b1;
          waitc    = 0;
          seen     = 1;
          ncoins++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_coin"}, 32'(coin_out), 32'(e));
          end
        end else begin
          waitc++;
        end
      end else if (seen) begin
        low++;
      end
      @(negedge clk);
      coin_ack = 1'b0;
    end
    chk({tag, "_done_seen"}, 32'(fin), 1);
    chk({tag, "_coin_count"}, 32'(ncoins), 32'(nexp));
  endtask

  initial begin
    int g, resid, cnt;

    hrst = 1'b1; req_valid = 1'b0; req_balance = '0; coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    hrst = 1'b0;
    @(negedge clk);

    // balance 40 -> Q, D, N
    resid = push_greedy(40);
    send_req(40);
    chk("t1_ready_busy", 32'(req_ready), 0);
    chk("t1_valid_early", 32'(coin_valid), 0);
    @(negedge clk);
    chk("t1_valid_rise", 32'(coin_valid), 1);
    serve("t1", 1, g);
    chk("t1_done", 32'(done), 1);
    chk("t1_short", 32'(short_change), 0);
    chk("t1_remaining", 32'(remaining), 32'(resid));
    chk("t1_coins", 32'(coins_issued), 3);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);

    // zero balance: done after the second edge following accept, no coin
    send_req(0);
    chk("t2_done_n1", 32'(done), 0);
    @(negedge clk);
    chk("t2_done_n2", 32'(done), 0);
    chk("t2_valid_n2", 32'(coin_valid), 0);
    @(negedge clk);
    chk("t2_done_n3", 32'(done), 1);
    chk("t2_valid_n3", 32'(coin_valid), 0);
    chk("t2_coins", 32'(coins_issued), 0);
    chk("t2_short", 32'(short_change), 0);
    @(negedge clk);

    // balance 7 -> one nickel, 2 cents short
    resid = push_greedy(7);
    send_req(7);
    serve("t3", 0, g);
    chk("t3_short", 32'(short_change), 1);
    chk("t3_remaining", 32'(remaining), 32'(resid));
    chk("t3_coins", 32'(coins_issued), 1);
    @(negedge clk);

    // balance 15 -> D, N with EJECT_GAP low cycles between them
    resid = push_greedy(15);
    send_req(15);
    serve("gap", 0, g);
    chk("gap_low_cycles", 32'(g), EJECT_GAP);
    chk("gap_remaining", 32'(remaining), 32'(resid));
    chk("gap_coins", 32'(coins_issued), 2);
    @(negedge clk);

    // balance 10 with a second request while busy -> ignored
    resid = push_greedy(10);
    send_req(10);
    req_valid = 1'b1; req_balance = 16'd5;
    chk("t6_ready_busy", 32'(req_ready), 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_remaining_kept", 32'(remaining), 10);
    serve("t6", 0, g);
    chk("t6_remaining", 32'(remaining), 32'(resid));
    chk("t6_coins", 32'(coins_issued), 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || coin_valid) cnt++;
    end
    chk("t6_no_second_req", 32'(cnt), 0);

    // balance 60, hrst after the first ack
    resid = push_greedy(60);
    send_req(60);
    @(negedge clk);
    chk("t5_valid", 32'(coin_valid), 1);
    chk("t5_coin", 32'(coin_out), 32'(exp_q.pop_front()));
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    chk("t5_remaining_mid", 32'(remaining), 35);
    chk("t5_coins_mid", 32'(coins_issued), 1);
    hrst = 1'b1;
    @(negedge clk);
    check_reset("t5_hrst");
    hrst = 1'b0;
    exp_q.delete();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (coin_valid) cnt++;
    end
    chk("t5_no_more_coins", 32'(cnt), 0);
    chk("t5_ready", 32'(req_ready), 1);

    // balance 25, ack withheld -> timeout fault
    resid = push_greedy(25);
    send_req(25);
    @(negedge clk);
    chk("t4_coin", 32'(coin_out), 32'(exp_q.pop_front()));
    cnt = 0;
    for (int i = 0; i <= ACK_TMO; i++) begin
      if (coin_valid) cnt++;
      @(negedge clk);
    end
    chk("t4_valid_cycles", 32'(cnt), ACK_TMO);
    chk("t4_valid_dropped", 32'(coin_valid), 0);
    chk("t4_fault", 32'(fault), 1);
    chk("t4_remaining", 32'(remaining), 25);
    chk("t4_ready", 32'(req_ready), 0);
    req_valid = 1'b1; req_balance = 16'd5;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    chk("t4_ready_stuck", 32'(req_ready), 0);
    chk("t4_fault_sticky", 32'(fault), 1);
    chk("t4_remaining_kept", 32'(remaining), 25);
    chk("t4_no_coin", 32'(coin_valid), 0);
    hrst = 1'b1;
    @(negedge clk);
    hrst = 1'b0;
    check_reset("t4_hrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
